// File: rtl/div_clock_monitor.sv
// div_clock_monitor: brings a divided clock into the clk domain, emits rise/fall strobes,
// measures half-periods and tracks lock. Optional glitch filter: DIVMON_GLITCH_FILTER_EN.
module div_clock_monitor #(
    parameter int CNT_W      = 8,
    parameter int HALF_MIN   = 5,
    parameter int HALF_MAX   = 7,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] half_len,
    output logic             len_valid,
    output logic             locked,
    output logic             err_stb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int GW = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

    logic s1, s2, hist, lvl, edge_det;

`ifdef DIVMON_GLITCH_FILTER_EN
    logic f0, f1, filt;

    // 2 of the last 3 synchronised samples must agree before a level is accepted
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            f0   <= 1'b0;
            f1   <= 1'b0;
            filt <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= div_in;
            s2   <= s1;
            f0   <= s2;
            f1   <= f0;
            filt <= (s2 & f0) | (s2 & f1) | (f0 & f1);
            hist <= filt;
        end
    end

    assign lvl = filt;
`else
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
        end else begin
            s1   <= div_in;
            s2   <= s1;
            hist <= s2;
        end
    end

    assign lvl = s2;
`endif

    assign edge_det = lvl ^ hist;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, len_new, half_len_nx;
    logic [GW-1:0]    good, good_nx;
    logic             legal, len_valid_nx, err_nx, locked_nx;

    always_comb begin
        state_nx     = state;
        good_nx      = good;
        half_len_nx  = half_len;
        len_valid_nx = 1'b0;
        err_nx       = 1'b0;
        len_new      = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
        cnt_nx       = len_new;
        legal        = (len_new >= CNT_W'(HALF_MIN)) && (len_new <= CNT_W'(HALF_MAX));

        if (edge_det) begin
            cnt_nx = '0;
            if (state != IDLE) begin
                half_len_nx  = len_new;
                len_valid_nx = 1'b1;
            end
            case (state)
                IDLE: begin
                    state_nx = ACQ;
                    good_nx  = '0;
                end
                ACQ: begin
                    if (legal) begin
                        good_nx = good + 1'b1;
                        if (good_nx == GW'(LOCK_COUNT))
                            state_nx = LOCKED;
                    end else begin
                        err_nx  = 1'b1;
                        good_nx = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        err_nx   = 1'b1;
                        good_nx  = '0;
                        state_nx = ACQ;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && cnt == CNT_MAX - 1'b1) begin
            // Counter about to saturate with no edge: the source has stopped.
            // IDLE never times out, so this fires once until an edge re-arms it.
            err_nx   = 1'b1;
            good_nx  = '0;
            state_nx = IDLE;
        end

        // lock shows one cycle after the qualifying len_valid, but drops at once
        locked_nx = (state == LOCKED) && (state_nx == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt       <= '0;
            good      <= '0;
            half_len  <= '0;
            len_valid <= 1'b0;
            err_stb   <= 1'b0;
            locked    <= 1'b0;
            rise_stb  <= 1'b0;
            fall_stb  <= 1'b0;
        end else begin
            cnt       <= cnt_nx;
            good      <= good_nx;
            half_len  <= half_len_nx;
            len_valid <= len_valid_nx;
            err_stb   <= err_nx;
            locked    <= locked_nx;
            rise_stb  <= edge_det & lvl;
            fall_stb  <= edge_det & ~lvl;
        end
    end

endmodule

// File: tb/tb_div_clock_monitor.sv
// Directed bench for div_clock_monitor: edge-time model checked every cycle, plus literal pins.
module tb_div_clock_monitor;
    localparam int CNT_W = 8;
    localparam int HMIN  = 5;
    localparam int HMAX  = 7;
    localparam int LOCKN = 4;
`ifdef DIVMON_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 5;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 3;
`endif

    logic clk = 1'b0, rst = 1'b0, div_in = 1'b0;
    logic rise_stb, fall_stb, len_valid, locked, err_stb;
    logic [CNT_W-1:0] half_len;

    div_clock_monitor #(.CNT_W(CNT_W), .HALF_MIN(HMIN), .HALF_MAX(HMAX), .LOCK_COUNT(LOCKN)) dut (
        .clk(clk), .rst(rst), .div_in(div_in),
        .rise_stb(rise_stb), .fall_stb(fall_stb), .half_len(half_len),
        .len_valid(len_valid), .locked(locked), .err_stb(err_stb)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int c = 0, last = 0, lock_cyc = 0, good = 0, hl = 0, errs = 0, lvs = 0;
    bit active = 1'b0, lk = 1'b0, rs = 1'b0;
    bit din_h [0:16383];

    always @(posedge clk) rs <= rst;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cyc %0d: got %0d expected %0d", nm, c, act, exp);
        end
    endtask

    function automatic bit d(input int k);
        return (k < 0) ? 1'b0 : din_h[k];
    endfunction

    function automatic bit mj(input int j);
        return (d(j) & d(j-1)) | (d(j) & d(j-2)) | (d(j-1) & d(j-2));
    endfunction

    // Model: div_in history indexed by cycle since reset; strobes are level changes
    // delayed by the pipeline latency, lengths are differences of strobe times.
    always @(negedge clk) begin
        bit er, ef, ev, ee, edg, lv_now;
        int len;
        er = 0; ef = 0; ev = 0; ee = 0;
        if (!rs) begin
            c = 0; din_h[0] = div_in;
            active = 0; lk = 0; good = 0; hl = 0; last = 0; lock_cyc = 0;
        end else begin
            c++;
            din_h[c] = div_in;
            if (FILT) begin
                edg = mj(c-4) != mj(c-5); lv_now = mj(c-4);
            end else begin
                edg = d(c-3) != d(c-4);   lv_now = d(c-3);
            end
            if (edg) begin
                er = lv_now; ef = !lv_now;
                if (active) begin
                    len = c - last;
                    if (len > 255) len = 255;
                    hl = len; ev = 1;
                    if (len >= HMIN && len <= HMAX) begin
                        if (!lk) begin
                            good++;
                            if (good == LOCKN) begin lk = 1; lock_cyc = c; end
                        end
                    end else begin
                        ee = 1; good = 0; lk = 0;
                    end
                end else begin
                    active = 1; good = 0;
                end
                last = c;
            end else if (active && c - last == 255) begin
                ee = 1; active = 0; lk = 0; good = 0;
            end
        end
        chk("rise_stb", rise_stb, er);
        chk("fall_stb", fall_stb, ef);
        chk("len_valid", len_valid, ev);
        chk("half_len", half_len, hl);
        chk("err_stb", err_stb, ee);
        chk("locked", locked, (lk && c > lock_cyc) ? 1 : 0);
        if (err_stb) errs++;
        if (len_valid) lvs++;
    end

    task automatic half(input int n);
        div_in = ~div_in;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int e0, l0, h0;
        // reset held 3 clk while div_in toggles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            div_in = (i == 0);
        end
        @(posedge clk); #1;
        rst = 1'b1;

        // steady 6-clk halves: first edge only arms, lock after 4 checked halves
        for (int i = 0; i < 8; i++) half(6);
        chk("lit_lv_count", lvs, 7);
        chk("lit_half6", half_len, 6);
        chk("lit_locked", locked, 1);
        chk("lit_no_err", errs, 0);

        // one 9-clk half breaks lock, four good halves regain it
        half(9);
        for (int i = 0; i < 6; i++) half(6);
        chk("lit_err_9", errs, 1);
        chk("lit_relock", locked, 1);

        // stopped source times out; next edge only re-arms
        repeat (270) @(posedge clk);
        #1;
        chk("lit_timeout_err", errs, 2);
        chk("lit_timeout_unlock", locked, 0);
        l0 = lvs;
        for (int i = 0; i < 3; i++) half(6);
        chk("lit_rearm_lv", lvs - l0, 2);

        // strobe latency and width
        if (div_in) half(6);
        for (int p = 0; p < 2; p++) begin
            div_in = ~div_in;
            for (int k = 1; k <= LAT + 2; k++) begin
                @(negedge clk);
                if (p == 0) chk("lit_rise_lat", rise_stb, (k == LAT + 1) ? 1 : 0);
                else        chk("lit_fall_lat", fall_stb, (k == LAT + 1) ? 1 : 0);
            end
            @(posedge clk); #1;
            repeat (6 - LAT - 2 > 0 ? 6 - LAT - 2 : 0) @(posedge clk);
            #1;
        end

        // 1-clk glitch on a low div_in
        e0 = errs; l0 = lvs; h0 = half_len;
        div_in = 1'b1;
        @(posedge clk); #1;
        div_in = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if (FILT) begin
            chk("lit_glitch_err", errs, e0);
            chk("lit_glitch_lv", lvs, l0);
            chk("lit_glitch_len", half_len, h0);
        end else begin
            chk("lit_glitch_err", errs, e0 + 1);
            chk("lit_glitch_len", half_len, 1);
        end

        // edge exactly at saturation: measured as 255, no timeout
        half(6);
        e0 = errs;
        half(255);
        half(6);
        chk("lit_sat_len", half_len, 255);
        chk("lit_sat_err", errs, e0 + 1);

        // mid-operation reset, then reacquire
        half(6); half(3);
        rst = 1'b0;
        @(posedge clk); #1;
        if (div_in) div_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 6; i++) half(6);
        chk("lit_reset_relock", locked, 1);
        chk("lit_reset_len", half_len, 6);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
